microroc_event_framer: RTL

Frames the 16-bit words deserialised from one MICROROC RAM readout into a self-describing event (header, payload, trailer) and buffers them toward the USB external FIFO. It sits downstream of the ASIC RAM readout stage and in parallel with the DAQ controller's data path. It is fed by the readout word stream plus the StartReadout/EndReadout strobes, and its output feeds the external FIFO write port.

---
 rtl/microroc_event_framer_pkg.sv | 29 ++
 rtl/microroc_event_framer_daq_word_fifo.sv | 83 ++++++++
 rtl/microroc_event_framer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/microroc_event_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microroc_event_framer_pkg
// Description : Shared constants and state encoding for the MICROROC event
//               framer. Holds the header/trailer marker words and the
//               framer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package microroc_event_framer_pkg;

    localparam logic [15:0] HEADER_MARK  = 16'hAA55;
    localparam logic [7:0]  HEADER_TAG   = 8'hC0;
    localparam logic [15:0] TRAILER_MARK = 16'h55AA;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'd0,
        ST_HDR0 = 4'd1,
        ST_HDR1 = 4'd2,
        ST_HDR2 = 4'd3,
        ST_DATA = 4'd4,
        ST_TRL0 = 4'd5,
        ST_TRL1 = 4'd6,
        ST_PASS = 4'd7
    } framerState_t;

endpackage
`default_nettype wire

// File: rtl/microroc_event_framer_daq_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : daq_word_fifo
// Description : Single-clock FIFO with registered full/empty flags. A push
//               while full is rejected, a pop while empty is ignored. The
//               head word is presented combinationally on o_popData.
// Revision    : 1.0 - initial release
// Ports       : clk        - clock
//               rst        - synchronous active-high flush
//               i_push     - write request
//               i_pushData - write data
//               i_pop      - read request (consumes o_popData)
//               o_popData  - current head word
//               o_full     - no room for another word
//               o_empty    - no word stored
// ============================================================================
module daq_word_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_popData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_ADDR_W     = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_COUNT = DEPTH[c_ADDR_W:0];

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wrPtr;
    logic [c_ADDR_W-1:0] r_rdPtr;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W:0]   w_countNext;
    logic                r_full;
    logic                r_empty;
    logic                w_doPush;
    logic                w_doPop;

    assign w_doPush = i_push && !r_full;
    assign w_doPop  = i_pop && !r_empty;

    always_comb begin
        w_countNext = r_count;
        case ({w_doPush, w_doPop})
            2'b10:   w_countNext = r_count + (c_ADDR_W + 1)'(1);
            2'b01:   w_countNext = r_count - (c_ADDR_W + 1)'(1);
            default: w_countNext = r_count;
        endcase
    end

    // Flags are computed from the next count so they are exact while
    // still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + c_ADDR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + c_ADDR_W'(1);
            r_count <= w_countNext;
            r_full  <= (w_countNext == c_FULL_COUNT);
            r_empty <= (w_countNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_popData = r_mem[r_rdPtr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/microroc_event_framer.sv
`default_nettype none
// ============================================================================
// Module      : microroc_event_framer
// Description : Wraps the words of one MICROROC RAM readout into an event
//               (AA55, C0/ChipID, EventCount, payload, WordCount, 55AA) or
//               passes words through unframed, buffering toward the USB
//               external FIFO.
// Revision    : 1.0 - initial release
// Ports       : Clk           - system clock (40 MHz)
//               Reset         - synchronous active-high reset
//               FrameEnable   - 1 framed, 0 transparent (sampled in IDLE)
//               ChipID        - chip identifier for header word 1
//               ReadoutStart  - readout begin pulse
//               ReadoutEnd    - readout end pulse
//               DataIn        - readout word
//               DataInEnable  - DataIn valid strobe
//               FifoFull      - external FIFO almost-full
//               DataOut       - word to external FIFO
//               DataOutEnable - external FIFO write strobe
//               EventCount    - completed framed events (wrapping)
//               Overflow      - sticky payload-drop flag
//               Busy          - framer active or buffer non-empty
// ============================================================================
module microroc_event_framer
    import microroc_event_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        FrameEnable,
    input  logic [7:0]  ChipID,
    input  logic        ReadoutStart,
    input  logic        ReadoutEnd,
    input  logic [15:0] DataIn,
    input  logic        DataInEnable,
    input  logic        FifoFull,
    output logic [15:0] DataOut,
    output logic        DataOutEnable,
    output logic [15:0] EventCount,
    output logic        Overflow,
    output logic        Busy
);

    framerState_t r_state;
    logic [7:0]   r_chipId;
    logic [15:0]  r_wordCount;
    logic [15:0]  r_eventCount;
    logic         r_overflow;
    logic         r_endPending;
    logic [15:0]  r_dataOut;
    logic         r_dataOutEnable;

    logic         w_push;
    logic [15:0]  w_pushData;
    logic         w_accept;
    logic         w_pop;
    logic         w_drop;
    logic         w_payloadState;
    logic [15:0]  w_fifoData;
    logic         w_fifoFull;
    logic         w_fifoEmpty;

    daq_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk        (Clk),
        .rst        (Reset),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_popData  (w_fifoData),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    // Word offered to the buffer in each state.
    always_comb begin
        w_push     = 1'b0;
        w_pushData = DataIn;
        case (r_state)
            ST_HDR0: begin w_push = 1'b1; w_pushData = HEADER_MARK;             end
            ST_HDR1: begin w_push = 1'b1; w_pushData = {HEADER_TAG, r_chipId};  end
            ST_HDR2: begin w_push = 1'b1; w_pushData = r_eventCount;            end
            ST_DATA: begin w_push = DataInEnable;                               end
            ST_TRL0: begin w_push = 1'b1; w_pushData = r_wordCount;             end
            ST_TRL1: begin w_push = 1'b1; w_pushData = TRAILER_MARK;            end
            ST_PASS: begin w_push = DataInEnable;                               end
            default: begin w_push = 1'b0;                                       end
        endcase
    end

    assign w_accept       = w_push && !w_fifoFull;
    assign w_pop          = !w_fifoEmpty && !FifoFull;
    assign w_payloadState = (r_state == ST_DATA) || (r_state == ST_PASS);
    // Any strobe that does not land in the buffer is a lost payload word.
    assign w_drop         = DataInEnable && !(w_payloadState && !w_fifoFull);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_IDLE;
            r_chipId        <= '0;
            r_wordCount     <= '0;
            r_eventCount    <= '0;
            r_overflow      <= 1'b0;
            r_endPending    <= 1'b0;
            r_dataOut       <= '0;
            r_dataOutEnable <= 1'b0;
        end else begin
            r_dataOutEnable <= w_pop;
            if (w_pop) r_dataOut <= w_fifoData;
            if (w_drop) r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!FrameEnable) begin
                        r_state <= ST_PASS;
                    end else if (ReadoutStart) begin
                        r_state      <= ST_HDR0;
                        r_chipId     <= ChipID;
                        r_wordCount  <= '0;
                        // A readout ending while the header is still being
                        // written must still close the event.
                        r_endPending <= ReadoutEnd;
                    end
                end
                ST_HDR0: begin
                    if (ReadoutEnd) r_endPending <= 1'b1;
                    if (w_accept) r_state <= ST_HDR1;
                end
                ST_HDR1: begin
                    if (ReadoutEnd) r_endPending <= 1'b1;
                    if (w_accept) r_state <= ST_HDR2;
                end
                ST_HDR2: begin
                    if (w_accept) begin
                        r_endPending <= 1'b0;
                        r_state      <= (r_endPending || ReadoutEnd) ? ST_TRL0 : ST_DATA;
                    end else if (ReadoutEnd) begin
                        r_endPending <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // Count only stored words; saturate rather than wrap.
                    if (w_accept && (r_wordCount != 16'hFFFF))
                        r_wordCount <= r_wordCount + 16'd1;
                    if (ReadoutEnd) r_state <= ST_TRL0;
                end
                ST_TRL0: begin
                    if (w_accept) r_state <= ST_TRL1;
                end
                ST_TRL1: begin
                    if (w_accept) begin
                        r_eventCount <= r_eventCount + 16'd1;
                        r_wordCount  <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_PASS: begin
                    if (FrameEnable) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign DataOut       = r_dataOut;
    assign DataOutEnable = r_dataOutEnable;
    assign EventCount    = r_eventCount;
    assign Overflow      = r_overflow;
    assign Busy          = (r_state != ST_IDLE) || !w_fifoEmpty;

endmodule
`default_nettype wire
